// File: rtl/dmux_1x2_16_buf_pkg.sv
// Shared definitions for the buffered 16-bit 1:2 demultiplexer.
package dmux_1x2_16_buf_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF = 2;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } ch_sel_e;

endpackage

// File: rtl/dmux_1x2_16_buf_fifo.sv
// Per-channel synchronous FIFO; head output reads as zero whenever the FIFO is empty.
module sync_fifo_16
  import dmux_1x2_16_buf_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not cleared on reset; the zero-gated head hides stale entries.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    head_data = '0;
    if (!empty) head_data = mem[rd_ptr];
  end

endmodule

// File: rtl/dmux_1x2_16_buf.sv
// Buffered 16-bit 1:2 demultiplexer: steers each accepted word into channel A or B FIFO.
module dmux_1x2_16_buf
  import dmux_1x2_16_buf_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       a_data,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [WIDTH-1:0]       b_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count
);

  ch_sel_e sel;
  logic    a_full, b_full, a_empty, b_empty;
  logic    push_a, push_b;

  assign sel      = ch_sel_e'(in_sel);
  // Ready depends only on the select and FIFO state, never on in_valid.
  assign in_ready = (sel == CH_B) ? ~b_full : ~a_full;
  assign push_a   = in_valid & in_ready & (sel == CH_A);
  assign push_b   = in_valid & in_ready & (sel == CH_B);
  assign a_valid  = ~a_empty;
  assign b_valid  = ~b_empty;

  sync_fifo_16 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .push      (push_a),
    .push_data (in_data),
    .pop       (a_ready),
    .full      (a_full),
    .empty     (a_empty),
    .count     (a_count),
    .head_data (a_data)
  );

  sync_fifo_16 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .push      (push_b),
    .push_data (in_data),
    .pop       (b_ready),
    .full      (b_full),
    .empty     (b_empty),
    .count     (b_count),
    .head_data (b_data)
  );

endmodule

// File: tb/tb_dmux_1x2_16_buf.sv
// Self-checking bench: directed vector table plus a queue-model random stream.
module tb_dmux_1x2_16_buf;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned NWORDS = 1000;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_valid, b_valid;
  logic             a_ready, b_ready;
  logic [1:0]       a_count, b_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmux_1x2_16_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic        sel;
    logic [15:0] d;
    logic        ar;
    logic        br;
    logic        chk_rdy;
    logic        rdy;
    logic        av;
    logic [15:0] ad;
    logic [1:0]  ac;
    logic        bv;
    logic [15:0] bd;
    logic [1:0]  bc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic iv, input logic sel, input logic [15:0] d,
                     input logic ar, input logic br, input logic chk_rdy, input logic rdy,
                     input logic av, input logic [15:0] ad, input logic [1:0] ac,
                     input logic bv, input logic [15:0] bd, input logic [1:0] bc);
    vec_t v;
    v.rst = rst; v.iv = iv; v.sel = sel; v.d = d; v.ar = ar; v.br = br;
    v.chk_rdy = chk_rdy; v.rdy = rdy;
    v.av = av; v.ad = ad; v.ac = ac; v.bv = bv; v.bd = bd; v.bc = bc;
    vecs.push_back(v);
  endtask

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  initial begin
    int accepted;
    int cycles;
    logic mrdy;

    reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;

    //   rst iv sel data     ar br chk rdy  av ad       ac  bv bd       bc
    // reset with traffic present: nothing is pushed
    add(1, 1, 0, 16'h1234, 1, 1, 0, 0,   0, 16'h0000, 0,  0, 16'h0000, 0);
    add(1, 1, 1, 16'h5678, 1, 1, 1, 1,   0, 16'h0000, 0,  0, 16'h0000, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 1, 1,   0, 16'h0000, 0,  0, 16'h0000, 0);
    add(0, 0, 1, 16'h0000, 0, 0, 1, 1,   0, 16'h0000, 0,  0, 16'h0000, 0);
    // single word to A, then drained
    add(0, 1, 0, 16'hA5A5, 0, 0, 1, 1,   1, 16'hA5A5, 1,  0, 16'h0000, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 1, 1,   0, 16'h0000, 0,  0, 16'h0000, 0);
    // fill B, B refuses, A still accepts
    add(0, 1, 1, 16'h0001, 0, 0, 1, 1,   0, 16'h0000, 0,  1, 16'h0001, 1);
    add(0, 1, 1, 16'h0002, 0, 0, 1, 1,   0, 16'h0000, 0,  1, 16'h0001, 2);
    add(0, 0, 1, 16'h0000, 0, 0, 1, 0,   0, 16'h0000, 0,  1, 16'h0001, 2);
    add(0, 0, 0, 16'h0000, 0, 0, 1, 1,   0, 16'h0000, 0,  1, 16'h0001, 2);
    add(0, 1, 1, 16'h0003, 0, 0, 1, 0,   0, 16'h0000, 0,  1, 16'h0001, 2);
    add(0, 1, 0, 16'h0A0A, 0, 0, 1, 1,   1, 16'h0A0A, 1,  1, 16'h0001, 2);
    // full B with pop and push together: pop only, push lands next cycle
    add(0, 1, 1, 16'h0003, 0, 1, 1, 0,   1, 16'h0A0A, 1,  1, 16'h0002, 1);
    add(0, 1, 1, 16'h0003, 0, 0, 1, 1,   1, 16'h0A0A, 1,  1, 16'h0002, 2);
    add(0, 0, 1, 16'h0000, 0, 1, 1, 0,   1, 16'h0A0A, 1,  1, 16'h0003, 1);
    add(0, 0, 1, 16'h0000, 0, 1, 1, 1,   1, 16'h0A0A, 1,  0, 16'h0000, 0);
    // both channels occupied, then reset discards everything
    add(0, 1, 1, 16'hBEEF, 0, 0, 1, 1,   1, 16'h0A0A, 1,  1, 16'hBEEF, 1);
    add(1, 1, 0, 16'h1111, 0, 0, 1, 1,   0, 16'h0000, 0,  0, 16'h0000, 0);
    add(0, 1, 0, 16'h2222, 0, 0, 1, 1,   1, 16'h2222, 1,  0, 16'h0000, 0);
    // push and pop same channel at count 1; then cross-channel push/pop
    add(0, 1, 0, 16'h4444, 1, 0, 1, 1,   1, 16'h4444, 1,  0, 16'h0000, 0);
    add(0, 1, 1, 16'h3333, 1, 0, 1, 1,   0, 16'h0000, 0,  1, 16'h3333, 1);
    add(0, 0, 0, 16'h0000, 0, 1, 1, 1,   0, 16'h0000, 0,  0, 16'h0000, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; in_valid = vecs[i].iv; in_sel = vecs[i].sel;
      in_data = vecs[i].d; a_ready = vecs[i].ar; b_ready = vecs[i].br;
      #1;
      if (vecs[i].chk_rdy) check("in_ready", i, 32'(in_ready), 32'(vecs[i].rdy));
      @(posedge clk); #1;
      check("a_valid", i, 32'(a_valid), 32'(vecs[i].av));
      check("a_data",  i, 32'(a_data),  32'(vecs[i].ad));
      check("a_count", i, 32'(a_count), 32'(vecs[i].ac));
      check("b_valid", i, 32'(b_valid), 32'(vecs[i].bv));
      check("b_data",  i, 32'(b_data),  32'(vecs[i].bd));
      check("b_count", i, 32'(b_count), 32'(vecs[i].bc));
    end

    // Random stream against per-channel queues (FIFO starts empty here).
    reset = 1'b0;
    accepted = 0;
    cycles = 0;
    while (accepted < NWORDS && cycles < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      a_ready  = ($urandom_range(0, 2) != 0);
      b_ready  = ($urandom_range(0, 2) != 0);
      #1;
      mrdy = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
      check("rnd_in_ready", cycles, 32'(in_ready), 32'(mrdy));
      check("rnd_a_count", cycles, 32'(a_count), 32'(qa.size()));
      check("rnd_b_count", cycles, 32'(b_count), 32'(qb.size()));
      check("rnd_a_valid", cycles, 32'(a_valid), 32'(qa.size() != 0));
      check("rnd_b_valid", cycles, 32'(b_valid), 32'(qb.size() != 0));
      check("rnd_a_data", cycles, 32'(a_data), (qa.size() != 0) ? 32'(qa[0]) : 32'h0);
      check("rnd_b_data", cycles, 32'(b_data), (qb.size() != 0) ? 32'(qb[0]) : 32'h0);
      if (a_ready && qa.size() != 0) void'(qa.pop_front());
      if (b_ready && qb.size() != 0) void'(qb.pop_front());
      if (in_valid && mrdy) begin
        if (in_sel) qb.push_back(in_data);
        else        qa.push_back(in_data);
        accepted++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    check("rnd_words_accepted", cycles, 32'(accepted), 32'(NWORDS));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
